lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameters: DM_ADDRESS, 9, byte-address width; DATA_W, 32, data width.
REQ-002 SHALL have ports: clk  input  1  clock, all flops on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid  input  1  pipeline presents memory op; req_ready  output  1  LSU accepts op.
REQ-005 SHALL have ports: mem_read  input  1; mem_write  input  1; funct3  input  3  instr[14:12]; addr  input  DM_ADDRESS  byte address; wdata  input  DATA_W  store data.
REQ-006 SHALL have ports: dm_raddr  output  32; dm_waddr  output  32, both word-aligned (bits[1:0]=0); dm_wdata  output  DATA_W; dm_wr  output  4  byte-lane write enables; dm_rdata  input  DATA_W, valid the cycle after dm_raddr changes.
REQ-007 SHALL have ports: resp_valid  output  1; resp_rdata  output  DATA_W; resp_err  output  2 (00 ok, 01 misaligned, 10 illegal funct3, 11 read+write both set); stall  output  1.

Function
REQ-008 SHALL accept an op on a rising edge with req_valid=1 and req_ready=1; req_ready=1 only in IDLE.
REQ-009 SHALL implement FSM states IDLE, WR, RD_ADDR, RD_DATA, RESP.
REQ-010 SHALL transition from IDLE on accept: store to WR; load to RD_ADDR; error to RESP; req_valid with neither read nor write set to IDLE, with no response.
REQ-011 SHALL transition WR->RESP, RD_ADDR->RD_DATA, RD_DATA->RESP, RESP->IDLE unconditionally.
REQ-012 SHALL assert stall whenever the state is not IDLE.
REQ-013 SHALL flag misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; byte ops never misaligned.
REQ-014 SHALL treat load funct3 outside {000,001,010,100,101} and store funct3 outside {000,001,010} as illegal (err 10).
REQ-015 SHALL give error precedence: both read and write set (11) over illegal (10) over misaligned (01).
REQ-016 SHALL, for an op in error, perform no memory access, keep dm_wr=0, and set resp_rdata=0.
REQ-017 SHALL, in WR, drive dm_waddr={addr[8:2],00} zero-extended and hold dm_wr nonzero for exactly that one cycle.
REQ-018 SHALL, in WR, drive SB: dm_wr=0001<<addr[1:0], wdata[7:0] replicated on all 4 lanes.
REQ-019 SHALL, in WR, drive SH: dm_wr=0011<<(2*addr[1]), wdata[15:0] replicated on both halves.
REQ-020 SHALL, in WR, drive SW: dm_wr=1111, dm_wdata=wdata.
REQ-021 SHALL, for loads, drive dm_raddr word-aligned in RD_ADDR and RD_DATA, sample dm_rdata at the end of RD_DATA, and select the lane by the captured addr[1:0].
REQ-022 SHALL extend loads as follows: LB/LH sign-extend; LBU/LHU zero-extend; LW unmodified.
REQ-023 SHALL assert resp_valid for exactly one cycle in RESP, with resp_rdata and resp_err stable in that cycle; the consumer is always ready.
REQ-024 SHALL set latency from the accept edge to resp_valid to 2 cycles for stores, 3 for loads, and 1 for errors.
REQ-025 SHALL ignore addr, wdata, funct3, mem_read and mem_write outside the accept edge; all are captured at accept.
REQ-026 SHALL hold dm_wr=0 in every state other than WR.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, and drive dm_wr=0, resp_valid=0, resp_rdata=0, resp_err=00, dm_raddr=0, dm_waddr=0, dm_wdata=0, stall=0, and req_ready=0.
REQ-028 SHALL abort any in-flight op when reset asserts mid-operation, with no response issued; a write in WR is cut off asynchronously.
REQ-029 SHALL keep req_ready=0 until the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place in shared package lsu_pkg: state enum, funct3 constants (LB..LHU, SB..SW), and the resp_err code enum.
REQ-031 SHALL contain one combinational sub-module, lsu_lane_align, performing store lane steering and load extraction/extension; lsu_ctrl holds the FSM and registers.

Verification
REQ-032 SHALL cover: SB addr=0x006, wdata=0xAB -> WR cycle dm_wr=0100, dm_wdata=0xABABABAB, dm_waddr=0x004; resp_valid 2 cycles after accept, err 00.
REQ-033 SHALL cover: LB addr=0x003 with dm_rdata=0x80123456 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; resp_valid 3 cycles after accept.
REQ-034 SHALL cover: LH addr=0x002 with dm_rdata=0x8001_7FFF -> 0xFFFF8001; LHU -> 0x00008001.
REQ-035 SHALL cover: SW addr=0x00A -> no dm_wr pulse, resp_err=01 one cycle after accept; funct3=011 load -> resp_err=10; read+write both set -> resp_err=11.
REQ-036 SHALL cover: rst_n low during RD_DATA -> immediate IDLE, no resp_valid; next load accepted normally after release.
REQ-037 SHALL cover: back-to-back req_valid held high -> req_ready low and stall high until RESP completes; second op accepted on the first IDLE edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// encodings, response error codes and the request classifier.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_RW       = 2'b11
    } lsu_err_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Precedence: read+write conflict, then illegal funct3, then misalignment.
    function automatic lsu_err_e classify_op(input logic       rd,
                                             input logic       wr,
                                             input logic [2:0] f3,
                                             input logic [1:0] a_lo);
        lsu_err_e e;
        e = ERR_OK;
        if (rd && wr) begin
            e = ERR_RW;
        end else if (rd) begin
            case (f3)
                F3_LB, F3_LBU: e = ERR_OK;
                F3_LH, F3_LHU: e = a_lo[0] ? ERR_MISALIGN : ERR_OK;
                F3_LW:         e = (a_lo != 2'b00) ? ERR_MISALIGN : ERR_OK;
                default:       e = ERR_ILLEGAL;
            endcase
        end else if (wr) begin
            case (f3)
                F3_SB:   e = ERR_OK;
                F3_SH:   e = a_lo[0] ? ERR_MISALIGN : ERR_OK;
                F3_SW:   e = (a_lo != 2'b00) ? ERR_MISALIGN : ERR_OK;
                default: e = ERR_ILLEGAL;
            endcase
        end else begin
            e = ERR_OK;
        end
        return e;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
interface lsu_ctrl_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [31:0]           dm_raddr;
    logic [31:0]           dm_waddr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [3:0]            dm_wr;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic [1:0]            resp_err;
    logic                  stall;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, wdata, dm_rdata,
        output req_ready, dm_raddr, dm_waddr, dm_wdata, dm_wr,
               resp_valid, resp_rdata, resp_err, stall
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, wdata, dm_rdata,
        input  req_ready, dm_raddr, dm_waddr, dm_wdata, dm_wr,
               resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction with
// sign/zero extension for loads.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] ld_word,
    output logic [3:0]        wr_mask,
    output logic [DATA_W-1:0] st_lanes,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    assign ld_byte_s = ld_word[{addr_lo, 3'b000} +: 8];
    assign ld_half_s = ld_word[{addr_lo[1], 4'b0000} +: 16];

    // Store: narrow data is replicated so every enabled lane sees it.
    always_comb begin
        wr_mask  = 4'b0000;
        st_lanes = st_data;
        case (funct3)
            F3_SB: begin
                wr_mask  = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
            end
            F3_SH: begin
                wr_mask  = 4'b0011 << {addr_lo[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            F3_SW: begin
                wr_mask  = 4'b1111;
                st_lanes = st_data;
            end
            default: begin
                wr_mask  = 4'b0000;
                st_lanes = st_data;
            end
        endcase
    end

    // Load: pick the addressed lane and extend it to full width.
    always_comb begin
        ld_data = {DATA_W{1'b0}};
        case (funct3)
            F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LW:   ld_data = ld_word;
            F3_LBU:  ld_data = {24'h000000, ld_byte_s};
            F3_LHU:  ld_data = {16'h0000, ld_half_s};
            default: ld_data = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op at a time, drives the
// data-memory bus from registers and returns a single-cycle response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e        state_q,      state_d;
    logic              req_ready_q,  req_ready_d;
    logic              stall_q,      stall_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    lsu_err_e          resp_err_q,   resp_err_d;
    logic [31:0]       dm_raddr_q,   dm_raddr_d;
    logic [31:0]       dm_waddr_q,   dm_waddr_d;
    logic [DATA_W-1:0] dm_wdata_q,   dm_wdata_d;
    logic [3:0]        dm_wr_q,      dm_wr_d;
    logic [1:0]        op_addr_lo_q, op_addr_lo_d;
    logic [2:0]        op_funct3_q,  op_funct3_d;

    logic              accept_s;
    lsu_err_e          req_err_s;
    logic [2:0]        al_funct3_s;
    logic [1:0]        al_addr_lo_s;
    logic [3:0]        wr_mask_s;
    logic [DATA_W-1:0] st_lanes_s;
    logic [DATA_W-1:0] ld_data_s;

    function automatic logic [31:0] word_addr(input logic [DM_ADDRESS-3:0] a_hi);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[DM_ADDRESS-1:2] = a_hi;
        return w;
    endfunction

    assign accept_s  = bus.req_valid && req_ready_q;
    assign req_err_s = classify_op(bus.mem_read, bus.mem_write, bus.funct3, bus.addr[1:0]);

    // Store steering uses the live request at accept; load extraction uses the captured op.
    assign al_funct3_s  = (state_q == ST_IDLE) ? bus.funct3 : op_funct3_q;
    assign al_addr_lo_s = (state_q == ST_IDLE) ? bus.addr[1:0] : op_addr_lo_q;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .funct3   (al_funct3_s),
        .addr_lo  (al_addr_lo_s),
        .st_data  (bus.wdata),
        .ld_word  (bus.dm_rdata),
        .wr_mask  (wr_mask_s),
        .st_lanes (st_lanes_s),
        .ld_data  (ld_data_s)
    );

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        dm_raddr_d   = dm_raddr_q;
        dm_waddr_d   = dm_waddr_q;
        dm_wdata_d   = dm_wdata_q;
        dm_wr_d      = 4'b0000;
        op_addr_lo_d = op_addr_lo_q;
        op_funct3_d  = op_funct3_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_addr_lo_d = bus.addr[1:0];
                    op_funct3_d  = bus.funct3;
                    if (!bus.mem_read && !bus.mem_write) begin
                        state_d = ST_IDLE;
                    end else if (req_err_s != ERR_OK) begin
                        state_d      = ST_RESP;
                        resp_err_d   = req_err_s;
                        resp_rdata_d = {DATA_W{1'b0}};
                    end else if (bus.mem_write) begin
                        state_d    = ST_WR;
                        dm_waddr_d = word_addr(bus.addr[DM_ADDRESS-1:2]);
                        dm_wdata_d = st_lanes_s;
                        dm_wr_d    = wr_mask_s;
                    end else begin
                        state_d    = ST_RD_ADDR;
                        dm_raddr_d = word_addr(bus.addr[DM_ADDRESS-1:2]);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_err_d   = ERR_OK;
                resp_rdata_d = {DATA_W{1'b0}};
            end
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                state_d      = ST_RESP;
                resp_err_d   = ERR_OK;
                resp_rdata_d = ld_data_s;
            end
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        resp_valid_d = (state_d == ST_RESP);
        req_ready_d  = (state_d == ST_IDLE);
        stall_d      = (state_d != ST_IDLE);
    end

    // State and all registered outputs; reset leaves req_ready low until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            stall_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_err_q   <= ERR_OK;
            dm_raddr_q   <= 32'h0000_0000;
            dm_waddr_q   <= 32'h0000_0000;
            dm_wdata_q   <= {DATA_W{1'b0}};
            dm_wr_q      <= 4'b0000;
            op_addr_lo_q <= 2'b00;
            op_funct3_q  <= 3'b000;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            stall_q      <= stall_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            dm_raddr_q   <= dm_raddr_d;
            dm_waddr_q   <= dm_waddr_d;
            dm_wdata_q   <= dm_wdata_d;
            dm_wr_q      <= dm_wr_d;
            op_addr_lo_q <= op_addr_lo_d;
            op_funct3_q  <= op_funct3_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.stall      = stall_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.dm_raddr   = dm_raddr_q;
    assign bus.dm_waddr   = dm_waddr_q;
    assign bus.dm_wdata   = dm_wdata_q;
    assign bus.dm_wr      = dm_wr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl: expected responses are queued at
// drive time and checked when resp_valid appears.
module tb_lsu_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        bit          chk_data;
    } resp_t;

    logic clk;
    logic rst_n;
    lsu_ctrl_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    resp_t       sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] mem [0:127];
    int          wr_cycles;
    logic [3:0]  wr_mask_seen;
    logic [31:0] wdata_seen;
    logic [31:0] waddr_seen;
    logic [31:0] raddr_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: read data valid the cycle after the address is presented.
    always @(posedge clk) bus.dm_rdata <= mem[bus.dm_raddr[8:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        chk({tag, ":resp_expected"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ":err"}, 32'(bus.resp_err), 32'(e.err));
            if (e.chk_data) chk({tag, ":rdata"}, bus.resp_rdata, e.rdata);
        end
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [8:0] a, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask

    task automatic scramble();
        bus.mem_read  = 1'($urandom);
        bus.mem_write = 1'($urandom);
        bus.funct3    = 3'($urandom);
        bus.addr      = 9'($urandom);
        bus.wdata     = $urandom;
    endtask

    // Issue one op from a negedge, then watch six cycles; exp_lat=0 means no response.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd, input int exp_lat,
                         input bit chk_data, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_err, input string tag);
        resp_t e;
        int    got_lat;
        chk({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        drive_req(rd, wr, f3, a, wd);
        if (exp_lat > 0) begin
            e.rdata = exp_rdata; e.err = exp_err; e.chk_data = chk_data;
            sb.push_back(e);
        end
        @(posedge clk);
        got_lat = 0; wr_cycles = 0; wr_mask_seen = 4'h0;
        wdata_seen = 32'h0; waddr_seen = 32'h0; raddr_seen = 32'h0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.req_valid = 1'b0;
                scramble();
                raddr_seen = bus.dm_raddr;
            end
            if (bus.dm_wr !== 4'h0) begin
                wr_cycles++;
                wr_mask_seen = bus.dm_wr;
                wdata_seen   = bus.dm_wdata;
                waddr_seen   = bus.dm_waddr;
            end
            if (bus.resp_valid === 1'b1) begin
                if (got_lat == 0) got_lat = n;
                check_resp(tag);
            end
        end
        chk({tag, ":latency"}, 32'(got_lat), 32'(exp_lat));
    endtask

    initial begin
        int ready_v [1:8];
        int stall_v [1:8];
        int resp_n  [$];
        int spurious;
        resp_t e;

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.funct3 = 3'b000; bus.addr = 9'h000; bus.wdata = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:req_ready",  32'(bus.req_ready),  32'd0);
        chk("rst:stall",      32'(bus.stall),      32'd0);
        chk("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst:resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst:resp_rdata", bus.resp_rdata,      32'h0);
        chk("rst:dm_wr",      32'(bus.dm_wr),      32'd0);
        chk("rst:dm_raddr",   bus.dm_raddr,        32'h0);
        chk("rst:dm_waddr",   bus.dm_waddr,        32'h0);
        chk("rst:dm_wdata",   bus.dm_wdata,        32'h0);
        rst_n = 1'b1;
        #1 chk("rst:ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);

        // Stores
        do_op(1'b0, 1'b1, 3'b000, 9'h006, 32'h0000_00AB, 2, 1'b0, 32'h0, 2'b00, "sb");
        chk("sb:dm_wr",     32'(wr_mask_seen), 32'h4);
        chk("sb:dm_wdata",  wdata_seen,        32'hABAB_ABAB);
        chk("sb:dm_waddr",  waddr_seen,        32'h0000_0004);
        chk("sb:wr_cycles", 32'(wr_cycles),    32'd1);
        do_op(1'b0, 1'b1, 3'b001, 9'h002, 32'h1234_5678, 2, 1'b0, 32'h0, 2'b00, "sh");
        chk("sh:dm_wr",     32'(wr_mask_seen), 32'hC);
        chk("sh:dm_wdata",  wdata_seen,        32'h5678_5678);
        chk("sh:dm_waddr",  waddr_seen,        32'h0000_0000);
        do_op(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 2'b00, "sw");
        chk("sw:dm_wr",     32'(wr_mask_seen), 32'hF);
        chk("sw:dm_wdata",  wdata_seen,        32'hDEAD_BEEF);
        chk("sw:dm_waddr",  waddr_seen,        32'h0000_0010);

        // Loads
        mem[0] = 32'h8012_3456;
        do_op(1'b1, 1'b0, 3'b000, 9'h003, 32'h0, 3, 1'b1, 32'hFFFF_FF80, 2'b00, "lb");
        chk("lb:dm_raddr", raddr_seen, 32'h0000_0000);
        chk("lb:wr_cycles", 32'(wr_cycles), 32'd0);
        do_op(1'b1, 1'b0, 3'b100, 9'h003, 32'h0, 3, 1'b1, 32'h0000_0080, 2'b00, "lbu");
        mem[0] = 32'h8001_7FFF;
        do_op(1'b1, 1'b0, 3'b001, 9'h002, 32'h0, 3, 1'b1, 32'hFFFF_8001, 2'b00, "lh");
        do_op(1'b1, 1'b0, 3'b101, 9'h002, 32'h0, 3, 1'b1, 32'h0000_8001, 2'b00, "lhu");
        do_op(1'b1, 1'b0, 3'b000, 9'h001, 32'h0, 3, 1'b1, 32'h0000_007F, 2'b00, "lb_pos");
        mem[2] = 32'h1357_9BDF;
        do_op(1'b1, 1'b0, 3'b010, 9'h008, 32'h0, 3, 1'b1, 32'h1357_9BDF, 2'b00, "lw");
        chk("lw:dm_raddr", raddr_seen, 32'h0000_0008);

        // Errors and precedence
        do_op(1'b0, 1'b1, 3'b010, 9'h00A, 32'h5555_AAAA, 1, 1'b1, 32'h0, 2'b01, "sw_mis");
        chk("sw_mis:wr_cycles", 32'(wr_cycles), 32'd0);
        do_op(1'b1, 1'b0, 3'b011, 9'h000, 32'h0, 1, 1'b1, 32'h0, 2'b10, "ld_ill");
        do_op(1'b1, 1'b1, 3'b000, 9'h000, 32'h0, 1, 1'b1, 32'h0, 2'b11, "rw");
        do_op(1'b1, 1'b1, 3'b111, 9'h003, 32'h0, 1, 1'b1, 32'h0, 2'b11, "rw_prec");
        do_op(1'b1, 1'b0, 3'b110, 9'h001, 32'h0, 1, 1'b1, 32'h0, 2'b10, "ill_prec");
        do_op(1'b1, 1'b0, 3'b001, 9'h005, 32'h0, 1, 1'b1, 32'h0, 2'b01, "lh_mis");
        do_op(1'b0, 1'b1, 3'b100, 9'h000, 32'h0, 1, 1'b1, 32'h0, 2'b10, "st_ill");
        chk("st_ill:wr_cycles", 32'(wr_cycles), 32'd0);
        do_op(1'b0, 1'b0, 3'b010, 9'h004, 32'h0, 0, 1'b0, 32'h0, 2'b00, "noop");

        // Reset during RD_DATA aborts the load without a response
        drive_req(1'b1, 1'b0, 3'b010, 9'h008, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort:stall",      32'(bus.stall),      32'd0);
        chk("abort:req_ready",  32'(bus.req_ready),  32'd0);
        chk("abort:resp_valid", 32'(bus.resp_valid), 32'd0);
        spurious = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) spurious++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) spurious++;
        end
        chk("abort:no_resp", 32'(spurious), 32'd0);
        mem[0] = 32'h8012_3456;
        do_op(1'b1, 1'b0, 3'b000, 9'h003, 32'h0, 3, 1'b1, 32'hFFFF_FF80, 2'b00, "after_abort");

        // Reset during WR cuts the write strobe off asynchronously
        drive_req(1'b0, 1'b1, 3'b000, 9'h000, 32'h0000_0011);
        @(posedge clk);
        #2;
        chk("cut:dm_wr_before", 32'(bus.dm_wr), 32'h1);
        rst_n = 1'b0;
        #1 chk("cut:dm_wr_after", 32'(bus.dm_wr), 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: req_valid held high across a store and a following load
        mem[8] = 32'h0000_C300;
        drive_req(1'b0, 1'b1, 3'b010, 9'h020, 32'h0BAD_F00D);
        e.rdata = 32'h0; e.err = 2'b00; e.chk_data = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                drive_req(1'b1, 1'b0, 3'b100, 9'h021, 32'h0);
                e.rdata = 32'h0000_00C3; e.err = 2'b00; e.chk_data = 1'b1;
                sb.push_back(e);
            end
            if (n == 4) bus.req_valid = 1'b0;
            ready_v[n] = int'(bus.req_ready);
            stall_v[n] = int'(bus.stall);
            if (bus.resp_valid === 1'b1) begin
                resp_n.push_back(n);
                check_resp("b2b");
            end
        end
        chk("b2b:ready_wr",   32'(ready_v[1]), 32'd0);
        chk("b2b:stall_wr",   32'(stall_v[1]), 32'd1);
        chk("b2b:ready_resp", 32'(ready_v[2]), 32'd0);
        chk("b2b:stall_resp", 32'(stall_v[2]), 32'd1);
        chk("b2b:ready_idle", 32'(ready_v[3]), 32'd1);
        chk("b2b:stall_idle", 32'(stall_v[3]), 32'd0);
        chk("b2b:stall_load", 32'(stall_v[4]), 32'd1);
        chk("b2b:resp_count", 32'(resp_n.size()), 32'd2);
        if (resp_n.size() == 2) begin
            chk("b2b:resp1_cycle", 32'(resp_n[0]), 32'd2);
            chk("b2b:resp2_cycle", 32'(resp_n[1]), 32'd6);
        end
        chk("end:sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
